rom_read_arbiter: RTL and testbench

- Shares one AXI4 read-only slave (instruction ROM) between NUM_MASTERS read requesters, e.g. instruction fetch and boot/debug loader.
- Arbitrates round-robin at burst granularity: a granted master owns AR and R channels until its burst completes.
- Sits between master ports and the ROM's AR/R channels; write channels are not handled.

---
 rtl/rom_read_arbiter_pkg.sv | 18 +
 rtl/rom_read_arbiter_rr_arbiter.sv | 28 ++
 rtl/rom_read_arbiter.sv | 147 ++++++++++++++
 tb/tb_rom_read_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_read_arbiter_pkg.sv
// Shared types and helpers for the ROM read arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Wide enough for up to four masters.
    localparam int IDX_W = 2;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int num);
        int nxt;
        nxt = int'(idx) + 1;
        if (nxt >= num) nxt = 0;
        return nxt[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/rom_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
)(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       idx
);

    always_comb begin
        grant = '0;
        idx   = ptr;
        // Scan from the farthest candidate back toward ptr so the nearest requester is written last.
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (req[j] && (j == (int'(ptr) + k) % NUM_MASTERS)) begin
                    grant    = '0;
                    grant[j] = 1'b1;
                    idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Burst-granular round-robin sharing of one AXI4 read-only ROM slave among NUM_MASTERS readers.
// Optional ARB_BEAT_COUNT_EN: burst end and m_rlast come from an arlen beat counter; adds sticky beat_err.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
    input  logic [NUM_MASTERS*8-1:0]          m_arlen,
    input  logic [NUM_MASTERS*3-1:0]          m_arsize,
    input  logic [NUM_MASTERS*2-1:0]          m_arburst,
    input  logic [NUM_MASTERS-1:0]            m_arvalid,
    output logic [NUM_MASTERS-1:0]            m_arready,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [1:0]                        m_rresp,
    output logic                              m_rlast,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    input  logic [NUM_MASTERS-1:0]            m_rready,
    output logic                              s_arid,
    output logic [ADDR_WIDTH-1:0]             s_araddr,
    output logic [7:0]                        s_arlen,
    output logic [2:0]                        s_arsize,
    output logic [1:0]                        s_arburst,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    input  logic                              s_rid,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic [1:0]                        s_rresp,
    input  logic                              s_rlast,
    input  logic                              s_rvalid,
`ifdef ARB_BEAT_COUNT_EN
    output logic                              beat_err,
`endif
    output logic                              s_rready
);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       gnt_idx_q, ptr_q, arb_idx;
    logic [NUM_MASTERS-1:0] gnt_oh_q, arb_oh;
    logic                   sel_arvalid, sel_rready;
    logic                   ar_go, r_go, burst_end;
    logic                   unused_rid;

    rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
        .req   (m_arvalid),
        .ptr   (ptr_q),
        .grant (arb_oh),
        .idx   (arb_idx)
    );

    assign s_arid     = 1'b0;
    assign m_rdata    = s_rdata;
    assign m_rresp    = s_rresp;
    assign unused_rid = s_rid;

    always_comb begin
        s_araddr    = '0;
        s_arlen     = '0;
        s_arsize    = '0;
        s_arburst   = '0;
        sel_arvalid = 1'b0;
        sel_rready  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_idx_q == IDX_W'(i)) begin
                s_araddr    = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_arlen     = m_arlen[i*8 +: 8];
                s_arsize    = m_arsize[i*3 +: 3];
                s_arburst   = m_arburst[i*2 +: 2];
                sel_arvalid = m_arvalid[i];
                sel_rready  = m_rready[i];
            end
        end
    end

    // Handshakes formed from the selected inputs so they do not loop through the FSM outputs.
    assign ar_go = sel_arvalid & s_arready;
    assign r_go  = s_rvalid & sel_rready;

    always_comb begin
        state_d   = state_q;
        s_arvalid = 1'b0;
        m_arready = '0;
        s_rready  = 1'b0;
        m_rvalid  = '0;
        case (state_q)
            IDLE: begin
                if (|m_arvalid) state_d = ADDR;
            end
            ADDR: begin
                s_arvalid = sel_arvalid;
                m_arready = gnt_oh_q & {NUM_MASTERS{s_arready}};
                if (ar_go) state_d = DATA;
            end
            DATA: begin
                s_rready = sel_rready;
                m_rvalid = gnt_oh_q & {NUM_MASTERS{s_rvalid}};
                if (r_go && burst_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            ptr_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |m_arvalid) begin
                gnt_idx_q <= arb_idx;
                gnt_oh_q  <= arb_oh;
            end
            if (state_q == DATA && r_go && burst_end) begin
                ptr_q <= rr_next(gnt_idx_q, NUM_MASTERS);
            end
        end
    end

`ifdef ARB_BEAT_COUNT_EN
    logic [7:0] beat_cnt_q;

    assign burst_end = (beat_cnt_q == 8'd0);
    assign m_rlast   = burst_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_cnt_q <= '0;
            beat_err   <= 1'b0;
        end else if (state_q == ADDR && ar_go) begin
            beat_cnt_q <= s_arlen;
        end else if (state_q == DATA && r_go) begin
            beat_cnt_q <= beat_cnt_q - 8'd1;
            if (s_rlast != burst_end) beat_err <= 1'b1;
        end
    end
`else
    assign burst_end = s_rlast;
    assign m_rlast   = s_rlast;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: random and directed bursts against a ROM slave model.
`timescale 1ns/1ps
module tb_rom_read_arbiter;
    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM*AW-1:0]  m_araddr;
    logic [NM*8-1:0]   m_arlen;
    logic [NM*3-1:0]   m_arsize;
    logic [NM*2-1:0]   m_arburst;
    logic [NM-1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              s_arid;
    logic [AW-1:0]     s_araddr;
    logic [7:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic              s_arvalid, s_arready, s_rid;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast, s_rvalid, s_rready;
`ifdef ARB_BEAT_COUNT_EN
    logic              beat_err;
`endif

    always #5 clk = ~clk;

    rom_read_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
`ifdef ARB_BEAT_COUNT_EN
        .beat_err  (beat_err),
`endif
        .s_rready  (s_rready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents as seen through the slave: a fixed function of address and beat number.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a, input int k);
        return a ^ (32'h9E37_0000 + 32'(k) * 32'h0001_0101);
    endfunction
    function automatic logic [1:0] rom_resp(input int k);
        return (k % 3 == 2) ? 2'b10 : 2'b00;
    endfunction

    // Scenario controls, written by the sequencer, read by the driver.
    int  issue_left [NM];
    int  req_seq    [NM];
    int  req_since  [NM];
    int  beats_seen [NM];
    int  fixed_len   = 0;
    int  req_pct     = 100;
    int  rready_mode = 0;
    bit  directed    = 1'b1;
    bit  bad_rlast   = 1'b0;
    beat_t         exp_q [NM][$];
    int            grant_log[$];
    logic [AW-1:0] ar_addr_log[$];
    int  last_g   = -1;
    int  last_end = -1;
    bit  sl_active = 1'b0;
    logic [AW-1:0] sl_addr;
    int  sl_len, sl_beat;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Masters and ROM slave: observe handshakes mid-cycle, update drive just after the edge.
    initial begin : driver
        logic [NM-1:0] ar_hs_c;
        logic          s_ar_hs_c, r_hs_c;
        logic [AW-1:0] cap_addr, addr_n;
        logic [7:0]    cap_len;
        int            len_n;
        beat_t         b;
        m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_arvalid = '0; m_rready = '0;
        s_arready = 1'b0; s_rid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
        for (int i = 0; i < NM; i++) begin
            issue_left[i] = 0; req_seq[i] = 0; req_since[i] = -1; beats_seen[i] = 0;
        end
        forever begin
            @(negedge clk);
            ar_hs_c   = m_arvalid & m_arready;
            s_ar_hs_c = s_arvalid & s_arready;
            r_hs_c    = s_rvalid & s_rready;
            cap_addr  = s_araddr;
            cap_len   = s_arlen;
            @(posedge clk);
            #1;
            if (!rst) begin
                m_arvalid = '0; s_rvalid = 1'b0; s_rlast = 1'b0; sl_active = 1'b0;
                for (int i = 0; i < NM; i++) begin
                    issue_left[i] = 0; req_since[i] = -1; exp_q[i].delete();
                end
            end else begin
                if (r_hs_c) begin
                    s_rvalid = 1'b0;
                    if (sl_beat == sl_len) sl_active = 1'b0;
                    else sl_beat++;
                end
                if (s_ar_hs_c) begin
                    sl_active = 1'b1; sl_addr = cap_addr; sl_len = int'(cap_len); sl_beat = 0;
                end
                if (sl_active && !s_rvalid && (directed || $urandom_range(3) != 0)) begin
                    s_rvalid = 1'b1;
                    s_rdata  = rom_word(sl_addr, sl_beat);
                    s_rresp  = rom_resp(sl_beat);
                    s_rlast  = !bad_rlast && (sl_beat == sl_len);
                end
                s_arready = directed ? 1'b1 : ($urandom_range(2) != 0);
                for (int i = 0; i < NM; i++) begin
                    if (ar_hs_c[i]) begin
                        m_arvalid[i] = 1'b0;
                        req_since[i] = -1;
                    end
                    if (!m_arvalid[i] && issue_left[i] > 0 && $urandom_range(99) < req_pct) begin
                        len_n  = (fixed_len >= 0) ? fixed_len : int'($urandom_range(7));
                        addr_n = directed ? 32'h10 + 32'(i) * 32'h1000 + 32'(req_seq[i]) * 32'h40
                                          : $urandom;
                        m_araddr[i*AW +: AW] = addr_n;
                        m_arlen[i*8 +: 8]    = 8'(len_n);
                        m_arsize[i*3 +: 3]   = 3'd2;
                        m_arburst[i*2 +: 2]  = 2'b01;
                        m_arvalid[i]         = 1'b1;
                        req_since[i] = cyc;
                        req_seq[i]++;
                        issue_left[i]--;
                        for (int k = 0; k <= len_n; k++) begin
                            b.data = rom_word(addr_n, k);
                            b.resp = rom_resp(k);
                            b.last = (k == len_n);
                            exp_q[i].push_back(b);
                        end
                    end
                    case (rready_mode)
                        0:       m_rready[i] = 1'b1;
                        1:       m_rready[i] = cyc[0];
                        default: m_rready[i] = ($urandom_range(3) != 0);
                    endcase
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every delivered beat and checks arbitration order.
    always @(negedge clk) begin : monitor
        beat_t exp_b, got_b;
        int    g;
        if (!rst) begin
            last_g = -1; last_end = -1;
        end else begin
            for (int i = 0; i < NM; i++) begin
                if (m_rvalid[i]) begin
                    n_tests++;
                    if (s_rready !== m_rready[i]) begin
                        n_fail++;
                        $display("FAIL rready_follow m%0d: s_rready %0b, m_rready %0b", i, s_rready, m_rready[i]);
                    end
                end
                if (m_arready[i]) begin
                    n_tests++;
                    if (s_araddr !== m_araddr[i*AW +: AW]) begin
                        n_fail++;
                        $display("FAIL araddr_mirror m%0d: got %h, expected %h", i, s_araddr, m_araddr[i*AW +: AW]);
                    end
                end
                if (m_rvalid[i] && m_rready[i]) begin
                    beats_seen[i]++;
                    n_tests++;
                    got_b.data = m_rdata; got_b.resp = m_rresp; got_b.last = m_rlast;
                    if (exp_q[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat m%0d: data %h last %0b, expected none", i, m_rdata, m_rlast);
                    end else begin
                        exp_b = exp_q[i].pop_front();
                        if (got_b !== exp_b)
                            begin
                                n_fail++;
                                $display("FAIL beat m%0d: got data %h resp %0d last %0b, expected data %h resp %0d last %0b",
                                         i, got_b.data, got_b.resp, got_b.last, exp_b.data, exp_b.resp, exp_b.last);
                            end
                    end
                    if (m_rlast) last_end = cyc;
                end
            end
            n_tests++;
            if ($countones(m_rvalid) > 1 || $countones(m_arready) > 1) begin
                n_fail++;
                $display("FAIL onehot: m_rvalid %b m_arready %b", m_rvalid, m_arready);
            end
            if (s_arvalid && s_arready) begin
                g = -1;
                for (int i = 0; i < NM; i++) if (m_arready[i]) g = i;
                grant_log.push_back(g);
                ar_addr_log.push_back(s_araddr);
                if (g >= 0 && last_g >= 0) begin
                    n_tests++;
                    if (g == last_g && req_since[1-g] >= 0 && req_since[1-g] <= last_end) begin
                        n_fail++;
                        $display("FAIL fairness: got grant %0d again, expected %0d waiting since cycle %0d", g, 1-g, req_since[1-g]);
                    end
                    if (directed && req_since[g] >= 0 && req_since[g] <= last_end) begin
                        n_tests++;
                        if (cyc - last_end != 2) begin
                            n_fail++;
                            $display("FAIL idle_gap: got %0d cycles end-to-AR, expected 2", cyc - last_end);
                        end
                    end
                end
                last_g = g;
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(issue_left[0] == 0 && issue_left[1] == 0 && m_arvalid == '0 &&
                 exp_q[0].size() == 0 && exp_q[1].size() == 0 && !sl_active) && n < budget) begin
            @(posedge clk); #3;
            n++;
        end
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d/%0d beats pending, expected 0", name, exp_q[0].size(), exp_q[1].size());
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #3 rst = 1'b1;
        end
        repeat (3) @(posedge clk);
        #3;
    endtask

    task automatic start(input int n0, input int n1, input int len);
        grant_log.delete();
        ar_addr_log.delete();
        for (int i = 0; i < NM; i++) begin
            beats_seen[i] = 0; req_seq[i] = 0;
        end
        fixed_len = len;
        issue_left[0] = n0;
        issue_left[1] = n1;
    endtask

    initial begin : sequencer
        int n;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("reset_m_arready", 64'(m_arready), 64'd0);
        chk("reset_m_rvalid",  64'(m_rvalid),  64'd0);
        chk("reset_s_arvalid", 64'(s_arvalid), 64'd0);
        chk("reset_s_rready",  64'(s_rready),  64'd0);
        chk("s_arid_tied",     64'(s_arid),    64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;

        start(1, 1, 2);
        wait_idle("contention", 300);
        chk("contention_count", 64'(grant_log.size()), 64'd2);
        for (int i = 0; i < 2 && i < grant_log.size(); i++)
            chk($sformatf("contention_grant%0d", i), 64'(grant_log[i]), 64'(i));

        start(3, 3, 1);
        wait_idle("fairness", 400);
        chk("fairness_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("fairness_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

        start(1, 0, 3);
        wait_idle("single", 200);
        chk("single_araddr", (ar_addr_log.size() > 0) ? 64'(ar_addr_log[0]) : 64'hDEAD, 64'h10);
        chk("single_beats_m0", 64'(beats_seen[0]), 64'd4);
        chk("single_beats_m1", 64'(beats_seen[1]), 64'd0);

        rready_mode = 1;
        start(1, 0, 3);
        wait_idle("backpressure", 200);
        chk("backpressure_beats", 64'(beats_seen[0]), 64'd4);

        directed = 1'b0; req_pct = 30; rready_mode = 2;
        start(15, 15, -1);
        wait_idle("random", 6000);
        chk("random_bursts", 64'(grant_log.size()), 64'd30);

        directed = 1'b1; req_pct = 100; rready_mode = 0;
        start(1, 0, 7);
        n = 0;
        while (exp_q[0].size() != 7 && n < 200) begin
            @(posedge clk); #3; n++;
        end
        chk("midburst_reached", 64'(n < 200), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #3;
        chk("midrst_m_arready", 64'(m_arready), 64'd0);
        chk("midrst_m_rvalid",  64'(m_rvalid),  64'd0);
        chk("midrst_s_arvalid", 64'(s_arvalid), 64'd0);
        chk("midrst_s_rready",  64'(s_rready),  64'd0);
        rst = 1'b1;
        @(posedge clk);
        #3;
        start(0, 1, 1);
        wait_idle("after_reset", 200);
        chk("after_reset_grant", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hF, 64'd1);
        chk("after_reset_beats", 64'(beats_seen[1]), 64'd2);

`ifdef ARB_BEAT_COUNT_EN
        chk("beat_err_clean", 64'(beat_err), 64'd0);
        bad_rlast = 1'b1;
        start(1, 0, 0);
        wait_idle("bad_rlast", 200);
        chk("bad_rlast_beats", 64'(beats_seen[0]), 64'd1);
        chk("beat_err_set", 64'(beat_err), 64'd1);
        bad_rlast = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
